sliding_window_gen: RTL and testbench
=====================================

SLIDING_WINDOW_GEN -- requirements
Module: sliding_window_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8: bits per channel sample.
REQ-002 SHALL have parameter CH, default 1: channels per pixel.
REQ-003 SHALL have parameter K, default 3: window size; legal values are odd 3..7.
REQ-004 SHALL have parameter IMG_W, default 225: pixels per line; legal range is K..4095.
REQ-005 SHALL have parameter IMG_H, default 225: lines per frame; legal range is K..4095.
REQ-006 SHALL have port clk, input, 1 bit: clock, all logic on rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port i_valid, input, 1 bit: input pixel valid.
REQ-009 SHALL have port i_ready, output, 1 bit: block can accept a pixel.
REQ-010 SHALL have port i_sof, input, 1 bit: start of frame; qualified by i_valid.
REQ-011 SHALL have port i_data, input, CH*DATA_W bits: pixel, raster order; channel n at bits [n*DATA_W +: DATA_W].
REQ-012 SHALL have port o_valid, output, 1 bit: window valid.
REQ-013 SHALL have port o_ready, input, 1 bit: downstream accepts window.
REQ-014 SHALL have port o_window, output, K*K*CH*DATA_W bits: element (r,c,ch) at offset ((r*K+c)*CH+ch)*DATA_W. Row 0 is the oldest line, column 0 is the leftmost pixel.
REQ-015 SHALL have port o_col, output, 12 bits: column of the window centre.
REQ-016 SHALL have port o_row, output, 12 bits: row of the window centre.
REQ-017 SHALL have port o_eof, output, 1 bit: marks the last window of a frame.
REQ-018 SHALL have port o_err, output, 1 bit: sticky frame-framing error.

Function
REQ-019 Input transfer SHALL occur when i_valid && i_ready; output transfer SHALL occur when o_valid && o_ready.
REQ-020 SHALL drive i_ready = !o_valid || o_ready, combinationally.
REQ-021 SHALL hold o_window, o_col, o_row and o_eof stable while o_valid && !o_ready.
REQ-022 SHALL keep K-1 line buffers of IMG_W entries per channel, plus a KxK shift window; each accepted pixel shifts one column into the window and updates the line buffers.
REQ-023 SHALL track input column x (0..IMG_W-1) and row y (0..IMG_H-1).
  - x wraps to 0 after IMG_W-1 and y increments.
  - After (IMG_W-1, IMG_H-1), both counters return to (0,0).
REQ-024 An accepted pixel with i_sof=1 SHALL be treated as (0,0) regardless of the counters.
REQ-025 An accepted pixel at (x,y) with x>=K-1 and y>=K-1 SHALL produce a window ending at that pixel, with o_valid asserted the next cycle (latency 1).
  - o_col = x-(K-1)/2.
  - o_row = y-(K-1)/2.
REQ-026 Pixels with x<K-1 or y<K-1 SHALL produce no window; no padding windows are emitted.
REQ-027 Each frame SHALL yield exactly (IMG_W-K+1)*(IMG_H-K+1) windows.
REQ-028 No emitted window SHALL contain pixels from two different frames.
REQ-029 o_eof SHALL be 1 only on the window produced by pixel (IMG_W-1, IMG_H-1).
REQ-030 Frames MAY follow back-to-back with no idle cycle.
REQ-031 o_valid SHALL deassert after an output transfer unless a new pixel is accepted in the same cycle.

Reset
REQ-032 While rst_n=0, the block SHALL hold o_valid=0, o_window=0, o_col=0, o_row=0, o_eof=0, o_err=0 and counters=(0,0).
REQ-033 Line buffer contents SHALL NOT be reset, so they can map to block RAM; stale contents SHALL never appear in an emitted window.
REQ-034 After reset is released mid-frame, the next accepted pixel SHALL be treated as (0,0).

Configuration
REQ-035 With macro SLIDING_WINDOW_FRAME_CHECK_EN defined, o_err SHALL set when a pixel with i_sof=1 is accepted while the counters are not (0,0). o_err is then cleared only by reset, and the frame still restarts per REQ-024.
REQ-036 Without SLIDING_WINDOW_FRAME_CHECK_EN, o_err SHALL be tied to 0 and no check logic SHALL be built; the o_err port remains present.

Verification (K=3, IMG_W=8, IMG_H=6, CH=1 unless stated)
REQ-037 Ramp frame with pixel=x+8y, i_sof on the first pixel, o_ready=1:
  - Exactly 24 windows.
  - First window is (0,1,2,8,9,10,16,17,18) with o_col=1, o_row=1, one cycle after pixel 18 is accepted.
  - o_eof on window 24 only.
REQ-038 Same frame with o_ready=0 held for 5 cycles during window 3: o_window is stable, i_ready=0, window 3 is unchanged when released, and 24 windows total.
REQ-039 i_sof re-asserted on pixel 20:
  - With the macro defined, o_err=1; without it, o_err=0.
  - The next window is (0,1,2,8,9,10,16,17,18) of the new frame.
REQ-040 rst_n pulsed low after pixel 30: o_valid=0 immediately; a following full ramp frame yields 24 correct windows.
REQ-041 Two back-to-back frames (second frame pixel=100+x+8y): 48 windows, and window 25 is (100,101,102,108,109,110,116,117,118).
REQ-042 CH=3 with ch1=255-ch0 and ch2=ch0: every window has ch1 elements equal to 255 minus the corresponding ch0 elements, and ch2 elements equal to the ch0 elements.

Source files
------------

// File: rtl/sliding_window_gen.sv
// KxK sliding-window generator over a raster pixel stream, using K-1 line buffers and a shift window.
// Define SLIDING_WINDOW_FRAME_CHECK_EN to flag an i_sof that arrives while the raster counters are not at (0,0).
module sliding_window_gen #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CH     = 1,
  parameter int unsigned K      = 3,
  parameter int unsigned IMG_W  = 225,
  parameter int unsigned IMG_H  = 225
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic                     i_sof,
  input  logic [CH*DATA_W-1:0]     i_data,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [K*K*CH*DATA_W-1:0] o_window,
  output logic [11:0]              o_col,
  output logic [11:0]              o_row,
  output logic                     o_eof,
  output logic                     o_err
);

  localparam int unsigned PW     = CH * DATA_W;
  localparam int unsigned AW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [11:0] X_LAST = 12'(IMG_W - 1);
  localparam logic [11:0] Y_LAST = 12'(IMG_H - 1);
  localparam logic [11:0] EDGE   = 12'(K - 1);
  localparam logic [11:0] HALF   = 12'((K - 1) / 2);

  logic [11:0]   x_q, y_q, x_eff, y_eff, x_nxt, y_nxt;
  logic [AW-1:0] addr;
  logic          accept, emit;
  logic [PW-1:0] lb [K-1][IMG_W];
  logic [PW-1:0] win [K][K];
  logic [PW-1:0] col_in [K];

  assign i_ready = !o_valid || o_ready;
  assign accept  = i_valid && i_ready;

  // i_sof forces the pixel to (0,0); every decision below uses the effective position
  always_comb begin
    x_eff = i_sof ? '0 : x_q;
    y_eff = i_sof ? '0 : y_q;
    addr  = x_eff[AW-1:0];
    emit  = (x_eff >= EDGE) && (y_eff >= EDGE);
    x_nxt = x_eff + 12'd1;
    y_nxt = y_eff;
    if (x_eff == X_LAST) begin
      x_nxt = '0;
      y_nxt = (y_eff == Y_LAST) ? '0 : y_eff + 12'd1;
    end
  end

  // lb[0] holds the line just above, lb[K-2] the oldest; col_in row 0 is the oldest line
  always_comb begin
    for (int unsigned r = 0; r < K - 1; r++) begin
      col_in[r] = lb[K-2-r][addr];
    end
    col_in[K-1] = i_data;
  end

  // Line buffers carry no reset so they can live in block RAM; windows only read lines of the current frame
  always_ff @(posedge clk) begin
    if (accept) begin
      lb[0][addr] <= i_data;
      for (int unsigned j = 1; j < K - 1; j++) begin
        lb[j][addr] <= lb[j-1][addr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      o_valid <= 1'b0;
      o_col   <= '0;
      o_row   <= '0;
      o_eof   <= 1'b0;
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c < K; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      if (accept) begin
        x_q <= x_nxt;
        y_q <= y_nxt;
        for (int unsigned r = 0; r < K; r++) begin
          for (int unsigned c = 0; c < K - 1; c++) begin
            win[r][c] <= win[r][c+1];
          end
          win[r][K-1] <= col_in[r];
        end
      end
      if (accept && emit) begin
        o_valid <= 1'b1;
        o_col   <= x_eff - HALF;
        o_row   <= y_eff - HALF;
        o_eof   <= (x_eff == X_LAST) && (y_eff == Y_LAST);
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  // The window only shifts on accept, and accept is blocked while stalled, so it is held for free
  always_comb begin
    o_window = '0;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) begin
        o_window[(r*K+c)*PW +: PW] = win[r][c];
      end
    end
  end

`ifdef SLIDING_WINDOW_FRAME_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_err <= 1'b0;
    end else if (accept && i_sof && ((x_q != '0) || (y_q != '0))) begin
      o_err <= 1'b1;
    end
  end
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_sliding_window_gen.sv
// Bench for sliding_window_gen (K=3, 8x6 frames): windows are checked against frame images kept in the bench.
module tb_sliding_window_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_sof = 1'b0;
  logic        o_ready = 1'b1;
  logic [7:0]  i_data = '0;
  logic        i_ready, o_valid, o_eof, o_err;
  logic [71:0] o_window;
  logic [11:0] o_col, o_row;
  logic [23:0] i_data3;
  logic        i_ready3, o_valid3, o_eof3, o_err3;
  logic [215:0] o_window3;
  logic [11:0] o_col3, o_row3;

  int nchk = 0;
  int nfail = 0;
  bit bp_en = 1'b0;
  bit hold = 1'b0;

`ifdef SLIDING_WINDOW_FRAME_CHECK_EN
  localparam bit EXP_ERR = 1'b1;
`else
  localparam bit EXP_ERR = 1'b0;
`endif
  localparam logic [71:0] FIRST_WIN = 72'h12_11_10_0A_09_08_02_01_00;
  localparam logic [71:0] B2B_WIN25 = 72'h76_75_74_6E_6D_6C_66_65_64;

  always #5 clk = ~clk;
  assign i_data3 = {i_data, 8'd255 - i_data, i_data};

  sliding_window_gen #(.DATA_W(8), .CH(1), .K(3), .IMG_W(8), .IMG_H(6)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready), .i_sof(i_sof),
    .i_data(i_data), .o_valid(o_valid), .o_ready(o_ready), .o_window(o_window),
    .o_col(o_col), .o_row(o_row), .o_eof(o_eof), .o_err(o_err));

  sliding_window_gen #(.DATA_W(8), .CH(3), .K(3), .IMG_W(8), .IMG_H(6)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready3), .i_sof(i_sof),
    .i_data(i_data3), .o_valid(o_valid3), .o_ready(o_ready), .o_window(o_window3),
    .o_col(o_col3), .o_row(o_row3), .o_eof(o_eof3), .o_err(o_err3));

  typedef struct {
    logic [71:0] w;
    logic [11:0] col;
    logic [11:0] row;
    logic        eof;
  } cap_t;

  cap_t         cap[$];
  logic [215:0] cap3[$];
  logic [7:0]   img [2][6][8];

  always @(posedge clk) begin
    #2;
    o_ready = hold ? 1'b0 : (bp_en ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  always @(negedge clk) begin : monitor
    cap_t t;
    if (rst_n && o_valid && o_ready) begin
      t.w = o_window; t.col = o_col; t.row = o_row; t.eof = o_eof;
      cap.push_back(t);
    end
    if (rst_n && o_valid3 && o_ready) cap3.push_back(o_window3);
  end

  // Window centred at (cx,cy) taken straight from the stored frame image
  function automatic logic [71:0] exp_win(input int f, input int cx, input int cy);
    logic [71:0] w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*8 +: 8] = img[f][cy-1+r][cx-1+c];
    return w;
  endfunction

  task automatic send_pix(input logic [7:0] d, input logic sof);
    int n = 0;
    i_valid = 1'b1; i_data = d; i_sof = sof;
    @(negedge clk);
    while (!i_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!i_ready) begin
      nfail++;
      $display("FAIL send_timeout: i_ready=%b after %0d cycles, want 1", i_ready, n);
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_sof = 1'b0;
  endtask

  task automatic send_frame(input int f, input int base, input bit rnd, input bit gaps,
                            input bit sof, input int p0, input int p1);
    logic [7:0] v;
    for (int p = p0; p <= p1; p++) begin
      v = rnd ? 8'($urandom_range(0, 255)) : 8'(base + p);
      img[f][p/8][p%8] = v;
      send_pix(v, sof && (p == 0));
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while (o_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (o_valid) begin
      nfail++;
      $display("FAIL drain_timeout: o_valid=%b after %0d cycles, want 0", o_valid, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    nchk++;
    if (o_valid !== 1'b0 || o_window !== '0 || o_col !== '0 || o_row !== '0 ||
        o_eof !== 1'b0 || o_err !== 1'b0 || i_ready !== 1'b1) begin
      nfail++;
      $display("FAIL reset_state: v=%b w=%h col=%0d row=%0d eof=%b err=%b rdy=%b, want all 0 and rdy=1",
               o_valid, o_window, o_col, o_row, o_eof, o_err, i_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ramp();
    cap.delete();
    send_frame(0, 0, 0, 0, 1, 0, 17);
    nchk++;
    if (o_valid !== 1'b0) begin
      nfail++;
      $display("FAIL ramp_no_early: o_valid=%b after pixel 17, want 0", o_valid);
    end
    send_frame(0, 0, 0, 0, 1, 18, 18);
    nchk++;
    if (o_valid !== 1'b1 || o_window !== FIRST_WIN || o_col !== 12'd1 || o_row !== 12'd1) begin
      nfail++;
      $display("FAIL ramp_first: v=%b w=%h col=%0d row=%0d, want v=1 w=%h col=1 row=1",
               o_valid, o_window, o_col, o_row, FIRST_WIN);
    end
    send_frame(0, 0, 0, 0, 1, 19, 47);
    drain();
    nchk++;
    if (cap.size() != 24) begin
      nfail++;
      $display("FAIL ramp_count: got %0d windows, want 24", cap.size());
    end
    if (cap.size() >= 24)
      for (int i = 0; i < 24; i++) begin
        nchk++;
        if (cap[i].w !== exp_win(0, 1+i%6, 1+i/6) || cap[i].col !== 12'(1+i%6) ||
            cap[i].row !== 12'(1+i/6) || cap[i].eof !== (i == 23)) begin
          nfail++;
          $display("FAIL ramp_win%0d: got w=%h col=%0d row=%0d eof=%b, want w=%h col=%0d row=%0d eof=%b",
                   i, cap[i].w, cap[i].col, cap[i].row, cap[i].eof, exp_win(0, 1+i%6, 1+i/6),
                   1+i%6, 1+i/6, i == 23);
        end
      end
  endtask

  task automatic test_stall();
    cap.delete();
    send_frame(0, 0, 0, 0, 1, 0, 20);
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      nchk++;
      if (o_valid !== 1'b1 || i_ready !== 1'b0 || o_window !== exp_win(0, 3, 1)) begin
        nfail++;
        $display("FAIL stall_cycle%0d: v=%b rdy=%b w=%h, want v=1 rdy=0 w=%h",
                 k, o_valid, i_ready, o_window, exp_win(0, 3, 1));
      end
    end
    hold = 1'b0;
    @(posedge clk); #1;
    send_frame(0, 0, 0, 0, 1, 21, 47);
    drain();
    nchk++;
    if (cap.size() != 24) begin
      nfail++;
      $display("FAIL stall_count: got %0d windows, want 24", cap.size());
    end
    if (cap.size() >= 24)
      for (int i = 0; i < 24; i++) begin
        nchk++;
        if (cap[i].w !== exp_win(0, 1+i%6, 1+i/6) || cap[i].eof !== (i == 23)) begin
          nfail++;
          $display("FAIL stall_win%0d: got w=%h eof=%b, want w=%h eof=%b",
                   i, cap[i].w, cap[i].eof, exp_win(0, 1+i%6, 1+i/6), i == 23);
        end
      end
  endtask

  task automatic test_sof_restart();
    cap.delete();
    send_frame(0, 0, 0, 0, 1, 0, 19);
    nchk++;
    if (o_err !== 1'b0) begin
      nfail++;
      $display("FAIL sof_err_before: o_err=%b, want 0", o_err);
    end
    send_frame(0, 0, 0, 0, 1, 0, 0);
    nchk++;
    if (o_err !== EXP_ERR) begin
      nfail++;
      $display("FAIL sof_err: o_err=%b, want %b", o_err, EXP_ERR);
    end
    send_frame(0, 0, 0, 0, 1, 1, 47);
    drain();
    nchk++;
    if (cap.size() != 26 || o_err !== EXP_ERR) begin
      nfail++;
      $display("FAIL sof_count: got %0d windows err=%b, want 26 err=%b", cap.size(), o_err, EXP_ERR);
    end
    if (cap.size() >= 26) begin
      nchk++;
      if (cap[2].w !== FIRST_WIN) begin
        nfail++;
        $display("FAIL sof_first_new: got w=%h, want %h", cap[2].w, FIRST_WIN);
      end
      for (int i = 0; i < 24; i++) begin
        nchk++;
        if (cap[2+i].w !== exp_win(0, 1+i%6, 1+i/6) || cap[2+i].eof !== (i == 23)) begin
          nfail++;
          $display("FAIL sof_win%0d: got w=%h eof=%b, want w=%h eof=%b",
                   i, cap[2+i].w, cap[2+i].eof, exp_win(0, 1+i%6, 1+i/6), i == 23);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    send_frame(0, 0, 0, 0, 1, 0, 30);
    rst_n = 1'b0;
    #1;
    nchk++;
    if (o_valid !== 1'b0 || o_window !== '0 || o_col !== '0 || o_row !== '0 || o_err !== 1'b0) begin
      nfail++;
      $display("FAIL midreset_state: v=%b w=%h col=%0d row=%0d err=%b, want all 0",
               o_valid, o_window, o_col, o_row, o_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cap.delete();
    send_frame(0, 0, 0, 0, 0, 0, 47);
    drain();
    nchk++;
    if (cap.size() != 24) begin
      nfail++;
      $display("FAIL midreset_count: got %0d windows, want 24", cap.size());
    end
    if (cap.size() >= 24)
      for (int i = 0; i < 24; i++) begin
        nchk++;
        if (cap[i].w !== exp_win(0, 1+i%6, 1+i/6) || cap[i].col !== 12'(1+i%6) ||
            cap[i].row !== 12'(1+i/6) || cap[i].eof !== (i == 23)) begin
          nfail++;
          $display("FAIL midreset_win%0d: got w=%h col=%0d row=%0d eof=%b, want w=%h col=%0d row=%0d",
                   i, cap[i].w, cap[i].col, cap[i].row, cap[i].eof, exp_win(0, 1+i%6, 1+i/6),
                   1+i%6, 1+i/6);
        end
      end
  endtask

  task automatic test_back_to_back();
    cap.delete();
    bp_en = 1'b1;
    send_frame(0, 0, 0, 0, 1, 0, 47);
    send_frame(1, 100, 0, 0, 1, 0, 47);
    drain();
    bp_en = 1'b0;
    nchk++;
    if (cap.size() != 48) begin
      nfail++;
      $display("FAIL b2b_count: got %0d windows, want 48", cap.size());
    end
    if (cap.size() >= 48) begin
      nchk++;
      if (cap[24].w !== B2B_WIN25) begin
        nfail++;
        $display("FAIL b2b_win25: got w=%h, want %h", cap[24].w, B2B_WIN25);
      end
      for (int i = 0; i < 48; i++) begin
        nchk++;
        if (cap[i].w !== exp_win(i/24, 1+(i%24)%6, 1+(i%24)/6) || cap[i].eof !== (i%24 == 23)) begin
          nfail++;
          $display("FAIL b2b_win%0d: got w=%h eof=%b, want w=%h eof=%b",
                   i, cap[i].w, cap[i].eof, exp_win(i/24, 1+(i%24)%6, 1+(i%24)/6), i%24 == 23);
        end
      end
    end
  endtask

  task automatic test_multichannel();
    logic [7:0] c0, c1, c2;
    bit bad;
    cap.delete();
    cap3.delete();
    bp_en = 1'b1;
    send_frame(0, 0, 1, 1, 1, 0, 47);
    send_frame(1, 0, 1, 1, 1, 0, 47);
    drain();
    bp_en = 1'b0;
    nchk++;
    if (cap.size() != 48 || cap3.size() != 48) begin
      nfail++;
      $display("FAIL mc_count: got %0d/%0d windows, want 48/48", cap.size(), cap3.size());
    end
    if (cap.size() >= 48 && cap3.size() >= 48)
      for (int i = 0; i < 48; i++) begin
        nchk++;
        if (cap[i].w !== exp_win(i/24, 1+(i%24)%6, 1+(i%24)/6) || cap[i].col !== 12'(1+(i%24)%6) ||
            cap[i].row !== 12'(1+(i%24)/6) || cap[i].eof !== (i%24 == 23)) begin
          nfail++;
          $display("FAIL rand_win%0d: got w=%h col=%0d row=%0d eof=%b, want w=%h col=%0d row=%0d",
                   i, cap[i].w, cap[i].col, cap[i].row, cap[i].eof,
                   exp_win(i/24, 1+(i%24)%6, 1+(i%24)/6), 1+(i%24)%6, 1+(i%24)/6);
        end
        bad = 1'b0;
        for (int e = 0; e < 9; e++) begin
          c0 = cap3[i][(e*3+0)*8 +: 8];
          c1 = cap3[i][(e*3+1)*8 +: 8];
          c2 = cap3[i][(e*3+2)*8 +: 8];
          if (c1 !== 8'd255 - c0 || c2 !== c0 || c0 !== img[i/24][(i%24)/6+e/3][(i%24)%6+e%3]) bad = 1'b1;
        end
        nchk++;
        if (bad) begin
          nfail++;
          $display("FAIL mc_win%0d: got w3=%h, want ch0=%h ch1=~ch0 ch2=ch0",
                   i, cap3[i], exp_win(i/24, 1+(i%24)%6, 1+(i%24)/6));
        end
      end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp();
    test_stall();
    test_sof_restart();
    test_reset_mid();
    test_back_to_back();
    test_multichannel();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
